// File: rtl/tlight_lamp_guard.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tlight_lamp_guard : lamp safety stage; trips to flashing yellow on bad input.
// Optional trip counter via TLG_FAULT_CNT_EN.            Revision 1.0
// -----------------------------------------------------------------------------
module tlight_lamp_guard #(
    parameter int FAULT_FILT = 2,
    parameter int MAX_HOLD   = 32,
    parameter int FLASH_HALF = 4,
    parameter int MIN_FLASH  = 64,
    parameter int ALLRED_CYC = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] ns,
    input  logic [2:0] we,
    input  logic       clear_fault,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_we,
    output logic       fault,
    output logic [1:0] fault_code
`ifdef TLG_FAULT_CNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam int FILT_W = $clog2(FAULT_FILT + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int FT_W   = $clog2(MIN_FLASH + 1);
    localparam int BL_W   = $clog2(FLASH_HALF + 1);
    localparam int AR_W   = $clog2(ALLRED_CYC + 1);

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        NORMAL = 2'd1,
        FLASH  = 2'd2
    } state_t;

    state_t            state;
    logic [FILT_W-1:0] filt_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [FT_W-1:0]   flash_tmr;
    logic [BL_W-1:0]   blink_cnt;
    logic              blink_on;
    logic [AR_W-1:0]   allred_tmr;
    logic [5:0]        prev_in;

    logic       conflict, illegal, stuck, changed, any_fault, trip, clear_ok;
    logic [1:0] cause;

    function automatic logic legal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b010) || (c == 3'b001) || (c == 3'b110);
    endfunction

    always_comb begin
        conflict  = ns[0] & we[0];
        illegal   = !legal(ns) || !legal(we);
        stuck     = (state == NORMAL) && (hold_cnt == HOLD_W'(MAX_HOLD));
        changed   = ({ns, we} != prev_in);
        cause     = conflict ? 2'b01 : (illegal ? 2'b10 : (stuck ? 2'b11 : 2'b00));
        any_fault = (cause != 2'b00);
        // Trip on the cycle that completes FAULT_FILT consecutive faulty samples.
        trip      = (state != FLASH) && any_fault && (filt_cnt >= FILT_W'(FAULT_FILT - 1));
        clear_ok  = (state == FLASH) && clear_fault && (flash_tmr == FT_W'(MIN_FLASH))
                    && !conflict && !illegal;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ALLRED;
            lamp_ns    <= 3'b100;
            lamp_we    <= 3'b100;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            filt_cnt   <= '0;
            hold_cnt   <= '0;
            flash_tmr  <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b0;
            allred_tmr <= '0;
            prev_in    <= '0;
`ifdef TLG_FAULT_CNT_EN
            fault_count <= 8'd0;
`endif
        end else begin
            prev_in <= {ns, we};
            case (state)
                ALLRED, NORMAL: begin
                    if (trip) begin
                        state      <= FLASH;
                        lamp_ns    <= 3'b010;
                        lamp_we    <= 3'b010;
                        fault      <= 1'b1;
                        fault_code <= cause;
                        filt_cnt   <= '0;
                        hold_cnt   <= '0;
                        flash_tmr  <= '0;
                        blink_cnt  <= '0;
                        blink_on   <= 1'b1;
                        allred_tmr <= '0;
`ifdef TLG_FAULT_CNT_EN
                        if (fault_count != 8'hFF)
                            fault_count <= fault_count + 8'd1;
`endif
                    end else if ((state == ALLRED) && (allred_tmr == AR_W'(ALLRED_CYC - 1))) begin
                        state      <= NORMAL;
                        lamp_ns    <= ns;
                        lamp_we    <= we;
                        filt_cnt   <= '0;
                        hold_cnt   <= '0;
                        allred_tmr <= '0;
                    end else begin
                        if (!any_fault)
                            filt_cnt <= '0;
                        else if (filt_cnt != FILT_W'(FAULT_FILT))
                            filt_cnt <= filt_cnt + 1'b1;
                        if (state == ALLRED) begin
                            allred_tmr <= allred_tmr + 1'b1;
                            lamp_ns    <= 3'b100;
                            lamp_we    <= 3'b100;
                        end else begin
                            lamp_ns <= ns;
                            lamp_we <= we;
                            if (changed)
                                hold_cnt <= '0;
                            else if (hold_cnt != HOLD_W'(MAX_HOLD))
                                hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                FLASH: begin
                    if (clear_ok) begin
                        state      <= ALLRED;
                        lamp_ns    <= 3'b100;
                        lamp_we    <= 3'b100;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                        flash_tmr  <= '0;
                        filt_cnt   <= '0;
                        hold_cnt   <= '0;
                        allred_tmr <= '0;
                    end else begin
                        if (flash_tmr != FT_W'(MIN_FLASH))
                            flash_tmr <= flash_tmr + 1'b1;
                        // Lamps are registered, so load the pattern of the next cycle.
                        if (blink_cnt == BL_W'(FLASH_HALF - 1)) begin
                            blink_cnt <= '0;
                            blink_on  <= ~blink_on;
                            lamp_ns   <= blink_on ? 3'b000 : 3'b010;
                            lamp_we   <= blink_on ? 3'b000 : 3'b010;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                            lamp_ns   <= blink_on ? 3'b010 : 3'b000;
                            lamp_we   <= blink_on ? 3'b010 : 3'b000;
                        end
                    end
                end
                default: state <= ALLRED;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tlight_lamp_guard.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_tlight_lamp_guard : randomized scoreboard bench for tlight_lamp_guard.
// -----------------------------------------------------------------------------
module tb_tlight_lamp_guard;

    localparam int FAULT_FILT = 2;
    localparam int MAX_HOLD   = 32;
    localparam int FLASH_HALF = 4;
    localparam int MIN_FLASH  = 64;
    localparam int ALLRED_CYC = 4;
    localparam int M_AR = 0, M_NORM = 1, M_FLASH = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] ns = 3'b100;
    logic [2:0] we = 3'b001;
    logic       clear_fault = 1'b0;
    logic [2:0] lamp_ns, lamp_we;
    logic       fault;
    logic [1:0] fault_code;
`ifdef TLG_FAULT_CNT_EN
    logic [7:0] fault_count;
`endif

    tlight_lamp_guard #(
        .FAULT_FILT(FAULT_FILT), .MAX_HOLD(MAX_HOLD), .FLASH_HALF(FLASH_HALF),
        .MIN_FLASH(MIN_FLASH), .ALLRED_CYC(ALLRED_CYC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ns(ns), .we(we), .clear_fault(clear_fault),
        .lamp_ns(lamp_ns), .lamp_we(lamp_we), .fault(fault), .fault_code(fault_code)
`ifdef TLG_FAULT_CNT_EN
        , .fault_count(fault_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] lns;
        logic [2:0] lwe;
        logic       f;
        logic [1:0] fc;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode, cycle index within mode, consecutive-fault run,
    // unchanged-input run in NORMAL, latched code and trip count.
    int         mode, t, bad, run, cnt;
    logic [1:0] code;
    logic [5:0] prev;
    logic [2:0] legal_codes [4];

    function automatic bit is_legal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b010) || (c == 3'b001) || (c == 3'b110);
    endfunction

    task automatic model_reset();
        mode = M_AR; t = 0; bad = 0; run = 0; cnt = 0; code = 2'b00; prev = 6'd0;
    endtask

    task automatic push_expected();
        exp_t e;
        case (mode)
            M_AR:    begin e.lns = 3'b100; e.lwe = 3'b100; end
            M_NORM:  begin e.lns = ns;     e.lwe = we;     end
            default: begin
                e.lns = (((t / FLASH_HALF) % 2) == 0) ? 3'b010 : 3'b000;
                e.lwe = e.lns;
            end
        endcase
        e.f   = (mode == M_FLASH);
        e.fc  = code;
        e.cnt = 8'(cnt);
        sb.push_back(e);
    endtask

    task automatic model_step();
        bit         cf, il, st;
        logic [1:0] cause;
        cf = ns[0] && we[0];
        il = !is_legal(ns) || !is_legal(we);
        st = (mode == M_NORM) && (run >= MAX_HOLD);
        cause = cf ? 2'b01 : (il ? 2'b10 : (st ? 2'b11 : 2'b00));
        if (mode != M_FLASH) begin
            if (cause != 2'b00 && bad + 1 >= FAULT_FILT) begin
                mode = M_FLASH; t = 0; code = cause; bad = 0; run = 0;
                if (cnt < 255) cnt++;
            end else if (mode == M_AR && t + 1 == ALLRED_CYC) begin
                mode = M_NORM; t = 0; bad = 0; run = 0;
            end else begin
                bad = (cause == 2'b00) ? 0 : ((bad < FAULT_FILT) ? bad + 1 : bad);
                if (mode == M_NORM)
                    run = ({ns, we} == prev) ? ((run < MAX_HOLD) ? run + 1 : run) : 0;
                t++;
            end
        end else if (clear_fault && t >= MIN_FLASH && !cf && !il) begin
            mode = M_AR; t = 0; code = 2'b00;
        end else begin
            t++;
        end
        prev = {ns, we};
        push_expected();
    endtask

    task automatic cycle(input logic [2:0] n, input logic [2:0] w, input logic c);
        ns = n; we = w; clear_fault = c;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        logic [8:0] got;
        reset_n = 1'b0;
        #2;
        got = {lamp_ns, lamp_we, fault, fault_code};
        n_checks++;
        if (got != 9'b100_100_0_00) begin
            n_fail++;
            $display("FAIL async_reset @%0t: got lamps=%b/%b fault=%b code=%b, want 100/100 0 00",
                     $time, lamp_ns, lamp_we, fault, fault_code);
        end
`ifdef TLG_FAULT_CNT_EN
        n_checks++;
        if (fault_count != 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_count @%0t: got %0d, want 0", $time, fault_count);
        end
`endif
        sb.delete();
        model_reset();
        @(posedge clock);
        push_expected();
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: lamps are valid every cycle, so one expectation is popped per cycle.
    initial begin
        exp_t e;
        bit   bad_cmp;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                bad_cmp = ({lamp_ns, lamp_we, fault, fault_code} != {e.lns, e.lwe, e.f, e.fc});
`ifdef TLG_FAULT_CNT_EN
                if (fault_count != e.cnt) bad_cmp = 1'b1;
`endif
                n_checks++;
                if (bad_cmp) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got lamps=%b/%b fault=%b code=%b, want lamps=%b/%b fault=%b code=%b cnt=%0d",
                             $time, lamp_ns, lamp_we, fault, fault_code, e.lns, e.lwe, e.f, e.fc, e.cnt);
                end
            end
        end
    end

    initial begin
        int         k, len;
        logic [2:0] a, b;
        legal_codes[0] = 3'b100; legal_codes[1] = 3'b010;
        legal_codes[2] = 3'b001; legal_codes[3] = 3'b110;
        model_reset();
        #1;
        do_reset();
        repeat (12) cycle(3'b100, 3'b001, 1'b0);
        cycle(3'b010, 3'b100, 1'b0);
        cycle(3'b001, 3'b001, 1'b0);
        cycle(3'b001, 3'b001, 1'b0);

        for (int s = 0; s < 400; s++) begin
            k   = $urandom_range(0, 9);
            a   = legal_codes[$urandom_range(0, 3)];
            b   = legal_codes[$urandom_range(0, 3)];
            len = $urandom_range(1, 12);
            case (k)
                5: begin a = 3'b111; len = 1; end
                6: begin a = 3'b011; len = $urandom_range(2, 3); end
                7: begin a = 3'b001; b = 3'b001; len = $urandom_range(1, 3); end
                8: begin a = 3'($urandom); b = 3'($urandom); len = $urandom_range(1, 3); end
                9: begin b = 3'b100; len = $urandom_range(30, 45); end
                default: ;
            endcase
            for (int i = 0; i < len; i++)
                cycle(a, b, ($urandom_range(0, 3) == 0));
            if (mode == M_FLASH && $urandom_range(0, 15) == 0)
                do_reset();
        end

        for (int i = 0; i < 10 && mode != M_FLASH; i++)
            cycle(3'b001, 3'b001, 1'b0);
        repeat (5) cycle(3'b100, 3'b001, 1'b0);
        do_reset();
        repeat (8) cycle(3'b100, 3'b001, 1'b0);
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
